// File: rtl/xsimbus_dev_pkg.sv
// Shared definitions for the xsimbus device port: FSM encodings, wait-counter width,
// reset polarity and the memory index-width helper.
package xsimbus_dev_pkg;

    localparam int   XSIMBUS_DEV_WAIT_W = 4;
    localparam logic RST_ENABLE_N       = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dev_state_e;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/xsimbus_dev_mem.sv
// DEPTH x DATA_W device memory: synchronous write, registered read port that holds
// its value until the next read.
module xsimbus_dev_mem
    import xsimbus_dev_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 8,
    parameter int IDX_W  = idx_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // NOTE: the array has no reset so it maps onto RAM; only the read register is reset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE_N) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/xsimbus_dev_port.sv
// Simulation-bus slave endpoint: claims transactions for DEV_ID, waits WAIT_CYCLES, then
// accesses local memory and acks. Define XSIMBUS_DEV_ERR_EN to flag addresses >= DEPTH.
module xsimbus_dev_port
    import xsimbus_dev_pkg::*;
#(
    parameter int DEV_ID      = 0,
    parameter int ID_W        = 5,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_hold_in,
    input  logic [ID_W-1:0]   bus_id_in,
    input  logic [ADDR_W-1:0] bus_addr_in,
    input  logic [DATA_W-1:0] bus_data_in,
    input  logic              bus_we_in,
    output logic [DATA_W-1:0] rdata_out,
    output logic              ack_out,
    output logic              busy_out,
    output logic              err_out
);

    localparam int                            IDX_W     = idx_width(DEPTH);
    localparam logic [ADDR_W:0]               DEPTH_W   = (ADDR_W+1)'(DEPTH);
    localparam logic [XSIMBUS_DEV_WAIT_W-1:0] WAIT_INIT = XSIMBUS_DEV_WAIT_W'(WAIT_CYCLES);
    localparam logic [XSIMBUS_DEV_WAIT_W-1:0] CNT_ONE   = XSIMBUS_DEV_WAIT_W'(1);
    localparam logic [ID_W-1:0]               MY_ID     = ID_W'(DEV_ID);

    dev_state_e                    r_state, w_state_nxt;
    logic [XSIMBUS_DEV_WAIT_W-1:0] r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0]             r_addr;
    logic [DATA_W-1:0]             r_data;
    logic                          r_we;
    logic                          r_ack, w_ack_nxt;
    logic                          r_busy, w_busy_nxt;
    logic                          w_capture;
    logic                          w_oob;
    logic                          w_mem_we, w_mem_re;
    logic [IDX_W-1:0]              w_mem_addr;
    logic [DATA_W-1:0]             w_mem_rdata;

`ifdef XSIMBUS_DEV_ERR_EN
    assign w_oob      = ({1'b0, r_addr} >= DEPTH_W);
    assign w_mem_addr = IDX_W'(r_addr);
`else
    assign w_oob      = 1'b0;
    assign w_mem_addr = IDX_W'({1'b0, r_addr} % DEPTH_W);
`endif

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_ack_nxt   = 1'b0;
        w_busy_nxt  = r_busy;
        w_mem_we    = 1'b0;
        w_mem_re    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus_hold_in && (bus_id_in == MY_ID)) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = WAIT_INIT;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A dropped hold flag abandons the transaction even on the final wait cycle.
                if (!bus_hold_in) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end else begin
                    w_ack_nxt   = 1'b1;
                    w_mem_we    = r_we & ~w_oob;
                    w_mem_re    = ~r_we & ~w_oob;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE_N) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_we    <= 1'b0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= w_ack_nxt;
            r_busy  <= w_busy_nxt;
            if (w_capture) begin
                r_addr <= bus_addr_in;
                r_data <= bus_data_in;
                r_we   <= bus_we_in;
            end
        end
    end

    xsimbus_dev_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (w_mem_we),
        .addr  (w_mem_addr),
        .wdata (r_data),
        .re    (w_mem_re),
        .rdata (w_mem_rdata)
    );

`ifdef XSIMBUS_DEV_ERR_EN
    logic r_err;
    logic r_rd_zero;

    // r_rd_zero masks the held read data to 0 from an error ack until the next good read.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE_N) begin
            r_err     <= 1'b0;
            r_rd_zero <= 1'b0;
        end else begin
            r_err <= w_ack_nxt & w_oob;
            if (w_ack_nxt && w_oob) begin
                r_rd_zero <= 1'b1;
            end else if (w_mem_re) begin
                r_rd_zero <= 1'b0;
            end
        end
    end

    assign err_out   = r_err;
    assign rdata_out = r_rd_zero ? '0 : w_mem_rdata;
`else
    assign err_out   = 1'b0;
    assign rdata_out = w_mem_rdata;
`endif

    assign ack_out  = r_ack;
    assign busy_out = r_busy;

endmodule
